// File: rtl/alu_pkg.sv
// Shared definitions for the ALU retire path: opcodes, flag layout and flag masking.
package alu_pkg;

    localparam logic [3:0] OPC_ADD = 4'd0;
    localparam logic [3:0] OPC_SUB = 4'd1;
    localparam logic [3:0] OPC_AND = 4'd2;
    localparam logic [3:0] OPC_OR  = 4'd3;
    localparam logic [3:0] OPC_SLL = 4'd4;
    localparam logic [3:0] OPC_MAX = 4'd4;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_V = 2;

    // Flag vector laid out as {overflow, zero, carry} so bit positions match FLG_*.
    typedef struct packed {
        logic v;
        logic z;
        logic c;
    } alu_flags_t;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Arithmetic ops keep all flags, logic/shift ops only keep zero,
    // unknown opcodes report a forced zero result.
    function automatic alu_flags_t mask_flags(input logic [3:0] opc,
                                              input logic       c,
                                              input logic       z,
                                              input logic       v);
        alu_flags_t f;
        f = '0;
        case (opc)
            OPC_ADD, OPC_SUB:          f = '{v: v,    z: z,    c: c};
            OPC_AND, OPC_OR, OPC_SLL:  f = '{v: 1'b0, z: z,    c: 1'b0};
            default:                   f = '{v: 1'b0, z: 1'b1, c: 1'b0};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer. in_ready is decoded from the state
// register only, so it has no combinational path from out_ready.
module alu_skid_buffer
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept;
    logic              retire;

    assign accept   = in_valid & in_ready;
    assign retire   = out_valid & out_ready;
    assign out_data = main_q;

    // State and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload entries are reset too, because the retired result must read 0 after reset.
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and payload movement.
    always_comb begin
        // NOTE: hold-by-default assignments keep every path assigned, so no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && retire) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = SKID_FULL;
                end else if (retire) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (retire) begin
                    main_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        out_valid = (state_q != SKID_EMPTY);
        in_ready  = (state_q != SKID_FULL);
    end

endmodule

// File: rtl/alu_result_stage.sv
// Retire stage behind the ALU: masks flags at accept, buffers through a skid
// buffer, accumulates sticky flags / illegal opcode and counts retirements.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_zero,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_opcode,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_flags,
    input  logic             sticky_clr,
    output logic [2:0]       sticky_flags,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int PAY_W = 4 + WIDTH + 3;

    alu_flags_t        in_flags_m;
    logic [WIDTH-1:0]  in_result_m;
    logic              in_illegal;
    logic [PAY_W-1:0]  in_payload;
    logic [PAY_W-1:0]  out_payload;
    logic              accept;
    logic              retire;

    logic [2:0]        sticky_q, sticky_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Mask flags and result before they enter the buffer.
    always_comb begin
        in_illegal  = (in_opcode > OPC_MAX);
        in_flags_m  = mask_flags(in_opcode, in_carry, in_zero, in_overflow);
        in_result_m = in_illegal ? '0 : in_result;
        in_payload  = {in_opcode, in_result_m, in_flags_m};
    end

    alu_skid_buffer #(
        .DATA_W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {out_opcode, out_result, out_flags} = out_payload;
    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    // Sticky status and retire counter; a same-cycle event survives the clear.
    always_comb begin
        sticky_d  = (sticky_clr ? 3'b000 : sticky_q) | (retire ? out_flags : 3'b000);
        illegal_d = (sticky_clr ? 1'b0 : illegal_q) | (accept & in_illegal);
        cnt_d     = retire ? cnt_q + 1'b1 : cnt_q;
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sticky_q  <= sticky_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sticky_flags = sticky_q;
    assign illegal_op   = illegal_q;
    assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (counter narrowed to 4 bits to reach the wrap).
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_opcode;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             in_zero;
    logic             in_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_opcode;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_flags;
    logic             sticky_clr;
    logic [2:0]       sticky_flags;
    logic             illegal_op;
    logic [CNT_W-1:0] retire_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_zero      (in_zero),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
        .illegal_op   (illegal_op),
        .retire_cnt   (retire_cnt)
    );

    typedef struct {
        logic [3:0]  opc;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
        logic [31:0] exp_res;
        logic [2:0]  exp_flags;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] opc, input logic [31:0] res,
                         input logic c, input logic z, input logic ov);
        in_valid    = v;
        in_opcode   = opc;
        in_result   = res;
        in_carry    = c;
        in_zero     = z;
        in_overflow = ov;
    endtask

    initial begin
        vecs[0] = '{4'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 3'b000, 1'b0};
        vecs[1] = '{4'd2, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 3'b010, 1'b0};
        vecs[2] = '{4'd7, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 3'b010, 1'b1};
        vecs[3] = '{4'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 3'b100, 1'b0};
        vecs[4] = '{4'd0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 3'b011, 1'b0};
        vecs[5] = '{4'd3, 32'h0000_F0F0, 1'b1, 1'b0, 1'b1, 32'h0000_F0F0, 3'b000, 1'b0};
        vecs[6] = '{4'd4, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 3'b000, 1'b0};
        vecs[7] = '{4'd5, 32'h0000_ABCD, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 3'b010, 1'b1};
        vecs[8] = '{4'd15, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 3'b010, 1'b1};

        rst_n      = 1'b0;
        out_ready  = 1'b1;
        sticky_clr = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_result", 64'(out_result), 64'd0);
        check("reset out_flags", 64'(out_flags), 64'd0);
        check("reset out_opcode", 64'(out_opcode), 64'd0);
        check("reset sticky", 64'(sticky_flags), 64'd0);
        check("reset illegal", 64'(illegal_op), 64'd0);
        check("reset cnt", 64'(retire_cnt), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Table: one op at a time into an empty stage with out_ready high.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].opc, vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].v);
            sticky_clr = 1'b1;
            step();
            drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
            sticky_clr = 1'b0;
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d out_result", i), 64'(out_result), 64'(vecs[i].exp_res));
            check($sformatf("vec%0d out_flags", i), 64'(out_flags), 64'(vecs[i].exp_flags));
            check($sformatf("vec%0d out_opcode", i), 64'(out_opcode), 64'(vecs[i].opc));
            check($sformatf("vec%0d illegal_op", i), 64'(illegal_op), 64'(vecs[i].exp_ill));
            step();
            exp_cnt = (exp_cnt + 1) % 16;
            check($sformatf("vec%0d drained", i), 64'(out_valid), 64'd0);
            check($sformatf("vec%0d sticky", i), 64'(sticky_flags), 64'(vecs[i].exp_flags));
            check($sformatf("vec%0d retire_cnt", i), 64'(retire_cnt), 64'(exp_cnt));
        end

        // Backpressure: A and B fill the buffer, C waits, then all drain in order.
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 32'hA, 1'b0, 1'b0, 1'b0);
        check("bp in_ready A", 64'(in_ready), 64'd1);
        step();
        drive(1'b1, 4'd0, 32'hB, 1'b0, 1'b0, 1'b0);
        check("bp in_ready B", 64'(in_ready), 64'd1);
        step();
        drive(1'b1, 4'd0, 32'hC, 1'b0, 1'b0, 1'b0);
        check("bp in_ready full", 64'(in_ready), 64'd0);
        check("bp head A", 64'(out_result), 64'hA);
        step();
        out_ready = 1'b1;
        check("bp hold in_ready", 64'(in_ready), 64'd0);
        check("bp hold head A", 64'(out_result), 64'hA);
        step();
        check("bp out B valid", 64'(out_valid), 64'd1);
        check("bp out B", 64'(out_result), 64'hB);
        check("bp in_ready after retire", 64'(in_ready), 64'd1);
        step();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("bp out C valid", 64'(out_valid), 64'd1);
        check("bp out C", 64'(out_result), 64'hC);
        step();
        exp_cnt = (exp_cnt + 3) % 16;
        check("bp drained", 64'(out_valid), 64'd0);
        check("bp retire_cnt", 64'(retire_cnt), 64'(exp_cnt));

        // Sticky: SUB overflow retires, then clear coincides with ADD carry retire.
        drive(1'b1, 4'd1, 32'h1, 1'b0, 1'b0, 1'b1);
        sticky_clr = 1'b1;
        step();
        drive(1'b1, 4'd0, 32'h2, 1'b1, 1'b0, 1'b0);
        sticky_clr = 1'b0;
        step();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        sticky_clr = 1'b1;
        check("sticky after SUB", 64'(sticky_flags), 64'b100);
        step();
        check("sticky clr+retire", 64'(sticky_flags), 64'b001);
        check("sticky stage empty", 64'(out_valid), 64'd0);
        step();
        sticky_clr = 1'b0;
        check("sticky clr only", 64'(sticky_flags), 64'b000);
        exp_cnt = (exp_cnt + 2) % 16;
        check("sticky retire_cnt", 64'(retire_cnt), 64'(exp_cnt));

        // Streaming at full rate: 18 retires take the 4-bit counter from 14 past 15 to 0.
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 4'd0, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
            if (i > 0) begin
                check($sformatf("stream%0d valid", i), 64'(out_valid), 64'd1);
                check($sformatf("stream%0d result", i), 64'(out_result), 64'(32'h100 + 32'(i - 1)));
            end
            check($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'd1);
            step();
        end
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("stream last result", 64'(out_result), 64'h111);
        step();
        check("stream drained", 64'(out_valid), 64'd0);
        check("stream wrap cnt", 64'(retire_cnt), 64'd0);
        check("stream sticky carry", 64'(sticky_flags), 64'b001);

        // Reset with the buffer full, then a single op after release.
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 32'h55, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'd0, 32'h66, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("pre-reset full", 64'(in_ready), 64'd0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out_result", 64'(out_result), 64'd0);
        check("midrst sticky", 64'(sticky_flags), 64'd0);
        check("midrst cnt", 64'(retire_cnt), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        drive(1'b1, 4'd1, 32'h77, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("post-rst valid", 64'(out_valid), 64'd1);
        check("post-rst result", 64'(out_result), 64'h77);
        step();
        check("post-rst drained", 64'(out_valid), 64'd0);
        check("post-rst cnt", 64'(retire_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered retire stage directly downstream of the 32-bit combinational ALU (ADD/SUB/AND/OR/SLL).
- Captures result, carry/zero/overflow and opcode through a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and carries no combinational path from out_ready.
- Masks flags that are meaningless for the opcode, accumulates sticky flags, and counts retired operations for the consumer (register file / status logic).

Parameters:
- WIDTH, 32, datapath width of the result.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU output valid.
- in_ready  output  1  stage can accept (registered).
- in_opcode  input  4  opcode the ALU evaluated.
- in_result  input  WIDTH  ALU result.
- in_carry  input  1  ALU carry flag.
- in_zero  input  1  ALU zero flag.
- in_overflow  input  1  ALU overflow flag.
- out_valid  output  1  retired entry valid.
- out_ready  input  1  consumer accepts.
- out_opcode  output  4  retired opcode.
- out_result  output  WIDTH  retired result.
- out_flags  output  3  {overflow, zero, carry} after masking.
- sticky_clr  input  1  synchronous clear of sticky flags and illegal_op.
- sticky_flags  output  3  OR of all retired out_flags since last clear.
- illegal_op  output  1  sticky: an opcode greater than 4 was accepted.
- retire_cnt  output  CNT_W  count of output handshakes, wraps.

Behaviour:
- Reset (async, rst_n low): out_valid=0, in_ready=1, out_opcode/out_result/out_flags=0, sticky_flags=0, illegal_op=0, retire_cnt=0, both buffer entries empty.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output retire = out_valid & out_ready.
  - Payload must hold while valid is high and ready is low (rule on both sides).
- Masking, applied at input accept before storage:
  - ADD/SUB: flags pass.
  - AND/OR/SLL: carry=0, overflow=0, zero passes.
  - Opcode >4: result stored as 0, flags forced to {0,1,0}, illegal_op set next cycle.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept & retire -> ONE, new data on the output.
    - Accept only -> FULL, data into the skid entry.
    - Retire only -> EMPTY.
  - FULL: out_valid=1, in_ready=0.
    - Retire -> ONE, skid entry moves to the output.
- Latency: 1 cycle from input accept to out_valid when the stage is empty. Throughput: 1 per cycle with out_ready held high.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- sticky_flags:
  - next = (sticky_clr ? 0 : sticky_flags) | (retire ? out_flags : 0).
  - Clear and a retire in the same cycle: the retiring flags survive the clear.
  - illegal_op follows the same rule, set at input accept.
- retire_cnt: +1 per retire, wraps from 2^CNT_W-1 to 0, unaffected by sticky_clr.
- Reset asserted mid-operation: buffered entries are discarded and all outputs return to reset values immediately. No retire is counted for discarded entries.
- in_valid while in_ready=0: ignored. The upstream holds its payload.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants ADD=0, SUB=1, AND=2, OR=3, SLL=4.
  - OPC_MAX=4.
  - Flag bit indices FLG_C=0, FLG_Z=1, FLG_V=2.
  - Packed result/flag struct typedef.
- Natural sub-module: alu_skid_buffer.
  - Generic 2-entry valid/ready skid parameterised on payload width.
  - The top level keeps masking, sticky flags and the counter.

Test Plan:
- Single op: ADD result 0xFFFF_FFFF, carry=0, zero=0, out_ready=1 -> out_valid one cycle later, out_flags=3'b000, retire_cnt=1.
- Masking: AND with carry=1, overflow=1, zero=1 -> out_flags=3'b010. Opcode 7 with result 0x1234 -> out_result=0, out_flags=3'b010, illegal_op=1.
- Backpressure:
  - Three back-to-back accepts with out_ready=0: first two accepted, in_ready=0 after the second.
  - Raise out_ready: outputs appear in order A, B, then C.
  - No gaps; retire_cnt=3.
- Sticky:
  - Retire SUB with overflow, then sticky_clr asserted in the same cycle as an ADD retire with carry -> sticky_flags=3'b001.
  - Next cycle with clr only -> 3'b000.
- Wrap: preload 0xFFFF retires (or CNT_W=4 with 16 retires) -> retire_cnt wraps to 0.
- Reset mid-traffic: rst_n low with the buffer FULL -> out_valid=0 and in_ready=1 immediately. After release, the first accepted op is the only output.
